// File: rtl/fp_sort_if.sv
// Stream bundle for fp_sort_engine: word input, sorted word output and status.
// A word moves on a rising edge only when its valid and ready are both high;
// valid never waits for ready, and data is held stable while valid&&!ready.
interface fp_sort_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        descending;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        sort_done;

  modport master (
    output in_valid, in_data, descending, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, sort_done
  );

  modport slave (
    input  in_valid, in_data, descending, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, sort_done
  );
endinterface

// File: rtl/fp_sort_engine.sv
// Block sorter for N IEEE-754 singles: load, in-place bubble sort using one
// shared A>=B float comparator, then drain. Includes the comparator module.
module compare (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        result
);
  logic mag_ge;
  logic mag_lt;

  assign mag_ge = (a[30:0] >= b[30:0]);
  assign mag_lt = (a[30:0] <  b[30:0]);

  // Negative values order inversely by magnitude; equal negatives answer 0.
  always_comb begin
    if (a[31] != b[31]) result = b[31];
    else if (!a[31])    result = mag_ge;
    else                result = mag_lt;
  end
endmodule

module fp_sort_engine #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  fp_sort_if.slave   sif,
  output logic [1:0] dbg_state,
  output logic       dbg_swap
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_J   = IDX_W'(N - 2);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] pass_q, pass_d;
  logic [IDX_W-1:0] j_q, j_d, j_nxt;
  logic             desc_q, desc_d;
  logic             done_q, done_d;
  logic [31:0]      mem_q [N];
  logic [31:0]      mem_d [N];

  logic [31:0] elem_lo, elem_hi, cmp_a, cmp_b;
  logic        cmp_ge, swap;
  logic        in_ready, out_valid, out_last, busy;
  logic [31:0] out_data;

  assign j_nxt   = j_q + 1'b1;
  assign elem_lo = mem_q[j_q];
  assign elem_hi = mem_q[j_nxt];
  assign cmp_a   = desc_q ? elem_lo : elem_hi;
  assign cmp_b   = desc_q ? elem_hi : elem_lo;

  compare u_compare (
    .a      (cmp_a),
    .b      (cmp_b),
    .result (cmp_ge)
  );

  // Identical bit patterns never swap, hiding the comparator's equal-negative answer.
  assign swap = (state_q == S_SORT) && (elem_lo != elem_hi) && !cmp_ge;

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    pass_d    = pass_q;
    j_d       = j_q;
    desc_d    = desc_q;
    done_d    = 1'b0;
    mem_d     = mem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (sif.in_valid) begin
          mem_d[wr_idx_q] = sif.in_data;
          wr_idx_d        = wr_idx_q + 1'b1;
          if (wr_idx_q == '0) desc_d = sif.descending;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            pass_d   = '0;
            j_d      = '0;
            state_d  = S_SORT;
          end
        end
      end
      S_SORT: begin
        busy = 1'b1;
        if (swap) begin
          mem_d[j_q]   = elem_hi;
          mem_d[j_nxt] = elem_lo;
        end
        if (j_q == LAST_J) begin
          j_d    = '0;
          pass_d = pass_q + 1'b1;
          if (pass_q == LAST_J) begin
            state_d  = S_DRAIN;
            rd_idx_d = '0;
            done_d   = 1'b1;
          end
        end else begin
          j_d = j_nxt;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_q[rd_idx_q];
        out_last  = (rd_idx_q == LAST_IDX);
        if (sif.out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            state_d  = S_LOAD;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      pass_q   <= '0;
      j_q      <= '0;
      desc_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      pass_q   <= pass_d;
      j_q      <= j_d;
      desc_q   <= desc_d;
      done_q   <= done_d;
    end
  end

  // Word storage carries no reset; contents are meaningless outside SORT/DRAIN.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign sif.in_ready  = in_ready;
  assign sif.out_valid = out_valid;
  assign sif.out_data  = out_data;
  assign sif.out_last  = out_last;
  assign sif.busy      = busy;
  assign sif.sort_done = done_q;
  assign dbg_state     = state_q;
  assign dbg_swap      = swap;
endmodule

// File: tb/tb_fp_sort_engine.sv
// Directed bench for fp_sort_engine: ordering, equal-word masking, backpressure,
// mid-operation reset and back-to-back blocks against a key-based reference sort.
module tb_fp_sort_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_sort_if sif ();
  logic [1:0] dbg_state;
  logic       dbg_swap;

  fp_sort_engine #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sif       (sif),
    .dbg_state (dbg_state),
    .dbg_swap  (dbg_swap)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int swap_cnt = 0;
  logic [31:0] blk     [8];
  logic [31:0] exp_blk [8];
  logic [31:0] asc_in  [8];
  logic [31:0] asc_out [8];
  logic [31:0] dsc_out [8];
  logic [31:0] stream  [16];
  logic [31:0] exp_q [$];

  always @(negedge clk) begin
    if (sif.sort_done) done_cnt++;
    if (dbg_swap)      swap_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_block(input logic desc0);
    int g;
    for (int i = 0; i < 8; i++) begin
      sif.in_valid   = 1'b1;
      sif.in_data    = blk[i];
      sif.descending = (i == 0) ? desc0 : ~desc0;
      g = 0;
      while (!sif.in_ready && g < 200) begin
        @(posedge clk); #1; g++;
      end
      if (!sif.in_ready) check("load_ready", 32'(sif.in_ready), 32'd1);
      @(posedge clk); #1;
    end
    sif.in_valid   = 1'b0;
    sif.descending = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!sif.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain_block(input bit bp, input int n_words);
    int k;
    int guard;
    logic rdy;
    k = 0;
    guard = 0;
    while (k < n_words && guard < 400) begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      sif.out_ready = rdy;
      check("out_valid", 32'(sif.out_valid), 32'd1);
      check("in_ready_drain", 32'(sif.in_ready), 32'd0);
      check($sformatf("out_data[%0d]", k), sif.out_data, exp_blk[k]);
      check($sformatf("out_last[%0d]", k), 32'(sif.out_last), 32'(k == 7));
      @(posedge clk); #1; guard++;
      if (rdy) k++;
    end
    sif.out_ready = 1'b0;
    check("drain_count", 32'(k), 32'(n_words));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(sif.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(sif.out_valid), 32'd0);
    check({tag, "_busy"},      32'(sif.busy),      32'd0);
  endtask

  task automatic full_block(input string tag, input logic desc0, input bit bp);
    int lat;
    int d0;
    d0 = done_cnt;
    load_block(desc0);
    wait_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'd49);
    check({tag, "_sort_done"}, 32'(sif.sort_done), 32'd1);
    drain_block(bp, 8);
    check_idle({tag, "_post"});
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(sif.out_valid), 32'd0);
    check({tag, "_out_last"},  32'(sif.out_last),  32'd0);
    check({tag, "_busy"},      32'(sif.busy),      32'd0);
    check({tag, "_sort_done"}, 32'(sif.sort_done), 32'd0);
    check({tag, "_out_data"},  sif.out_data,       32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(sif.in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  task automatic ref_push(input int base);
    logic [31:0] tmp [8];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) tmp[i] = stream[base + i];
    for (int i = 1; i < 8; i++) begin
      for (int m = i; m > 0; m--) begin
        if (fkey(tmp[m]) < fkey(tmp[m-1])) begin
          t = tmp[m]; tmp[m] = tmp[m-1]; tmp[m-1] = t;
        end
      end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(tmp[i]);
  endtask

  initial begin
    int sw0;
    int got;
    asc_in  = '{32'h40400000, 32'hBF800000, 32'h3F000000, 32'h40000000,
                32'hC0400000, 32'h3F800000, 32'h00000000, 32'h80000000};
    asc_out = '{32'hC0400000, 32'hBF800000, 32'h80000000, 32'h00000000,
                32'h3F000000, 32'h3F800000, 32'h40000000, 32'h40400000};
    dsc_out = '{32'h40400000, 32'h40000000, 32'h3F800000, 32'h3F000000,
                32'h00000000, 32'h80000000, 32'hBF800000, 32'hC0400000};
    stream  = '{32'h7F800000, 32'h00000001, 32'h007FFFFF, 32'hFF800000,
                32'h80000001, 32'h3F800000, 32'h7FC00000, 32'hC2C80000,
                32'h41200000, 32'h41200000, 32'hBF000000, 32'h00800000,
                32'h80800000, 32'h00000000, 32'h42C80000, 32'hC1200000};

    rst_n = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data = '0;
    sif.descending = 1'b0;
    sif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 32'(sif.in_ready), 32'd1);

    // Ascending block: 18 inversions means 18 swaps.
    blk = asc_in; exp_blk = asc_out; sw0 = swap_cnt;
    full_block("asc", 1'b0, 1'b0);
    check("asc_swaps", 32'(swap_cnt - sw0), 32'd18);

    // Descending latched from the first word only; 28-18 swaps.
    exp_blk = dsc_out; sw0 = swap_cnt;
    full_block("dsc", 1'b1, 1'b0);
    check("dsc_swaps", 32'(swap_cnt - sw0), 32'd10);

    // Identical negative words must never swap.
    for (int i = 0; i < 8; i++) begin
      blk[i] = 32'hBF800000; exp_blk[i] = 32'hBF800000;
    end
    sw0 = swap_cnt;
    full_block("eq", 1'b0, 1'b0);
    check("eq_swaps", 32'(swap_cnt - sw0), 32'd0);

    // Random out_ready during drain.
    blk = asc_in; exp_blk = asc_out;
    full_block("bp", 1'b0, 1'b1);

    // Reset in the middle of SORT, then a clean descending block.
    blk = asc_in;
    load_block(1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("mid_sort_busy", 32'(sif.busy), 32'd1);
    pulse_reset("rst_sort");
    exp_blk = dsc_out;
    full_block("after_rst_sort", 1'b1, 1'b0);

    // Reset after three drained words, then a clean ascending block.
    begin
      int lat;
      exp_blk = asc_out;
      load_block(1'b0);
      wait_out(lat);
      check("pre_rst_latency", 32'(lat), 32'd49);
      drain_block(1'b0, 3);
    end
    pulse_reset("rst_drain");
    full_block("after_rst_drain", 1'b0, 1'b0);

    // Back-to-back blocks with in_valid held high across the drain.
    ref_push(0);
    ref_push(8);
    got = 0;
    fork
      begin
        int g;
        for (int i = 0; i < 16; i++) begin
          sif.in_valid = 1'b1;
          sif.in_data = stream[i];
          sif.descending = 1'b0;
          g = 0;
          while (!sif.in_ready && g < 300) begin
            @(posedge clk); #1; g++;
          end
          @(posedge clk); #1;
        end
        sif.in_valid = 1'b0;
      end
      begin
        int mg;
        mg = 0;
        sif.out_ready = 1'b1;
        while (got < 16 && mg < 600) begin
          if (sif.out_valid) begin
            check($sformatf("b2b_data[%0d]", got), sif.out_data, exp_q.pop_front());
            got++;
          end
          @(posedge clk); #1; mg++;
        end
        sif.out_ready = 1'b0;
      end
    join
    check("b2b_count", 32'(got), 32'd16);
    check("b2b_left", 32'(exp_q.size()), 32'd0);
    check_idle("b2b_post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
